note_player: RTL
================

Name: note_player

Overview:
Consumer side of the random-note path. Requests a note index from the note generator, captures it, and plays it as a square wave for a fixed duration, followed by a silent gap. It then requests the next note. Sits between the note RNG and the audio output stage.

Parameters:
NOTE_CYCLES, 2500000, clock cycles a note sounds (250 ms at 10 MHz)
GAP_CYCLES, 250000, clock cycles of silence after each note
DIV_W, 16, width of the half-period counter

Ports:
clk  input  1  system clock
nrst  input  1  asynchronous active-low reset
en  input  1  playback enable
note_valid  input  1  single-cycle strobe: note is valid
note  input  6  note index 0..63
note_req  output  1  single-cycle request for the next note (drives RNG pulse)
wave_out  output  1  square-wave audio output
busy  output  1  high in PLAY or GAP
cur_note  output  6  last captured note index

Behaviour:
- Reset (async, nrst low): state IDLE, note_req=0, wave_out=0, busy=0, cur_note=0, all counters 0. Reset mid-note aborts the note immediately.
- States: IDLE, REQ, WAIT, PLAY, GAP.
- IDLE: if en=1, go to REQ next cycle.
- REQ: note_req=1 for exactly this cycle, then go to WAIT.
- WAIT:
  - on note_valid=1, capture note into cur_note, load the half-period, and go to PLAY.
  - note_valid is ignored in every other state.
- PLAY:
  - wave_out=1 on the first PLAY cycle.
  - Half counter counts 0..half_period-1. At the terminal count, wave_out toggles and the counter clears.
  - Duration counter counts NOTE_CYCLES cycles, then go to GAP.
- GAP: wave_out=0 for GAP_CYCLES cycles. Then go to REQ if en=1, else IDLE.
- en=0 in REQ/WAIT/PLAY/GAP: next state IDLE, wave_out=0 next cycle. en low beats a simultaneous note_valid.
- Latency: note_valid at cycle N gives PLAY with wave_out=1 at N+1.
- Half-period computation:
  - octave = note/12 (0..5), semitone = note%12.
  - half_period = BASE_HALF[semitone] >> octave, clamped to a minimum of 1.
  - Division is by compare chain; no divider.
- BASE_HALF is the octave-0 table (C3..B3 at 10 MHz): C=38223, C#=36077, D=34052, D#=32141, E=30337, F=28635, F#=27027, G=25510, A=22727, A#=21452, B=20248.
- busy=1 in PLAY and GAP only.

Optional Feature:
REST_EN:
- Defined: note index 0 is a rest. PLAY runs its full duration with wave_out held 0 and busy=1.
- Undefined: note 0 plays C3 (half_period 38223).

Decomposition:
- Package note_pkg:
  - state enum (IDLE, REQ, WAIT, PLAY, GAP)
  - BASE_HALF table as a 12-entry constant array
  - NOTES_PER_OCT=12
  - function for note -> {octave, semitone}
- One sub-module, tone_gen:
  - inputs: load, half_period, run
  - output: wave
  - holds the half counter and toggle flop.
- The top holds the FSM and the duration/gap counters.

Test Plan:
Use NOTE_CYCLES=100000 and GAP_CYCLES=10 for all scenarios.
- Reset with en=1 held: note_req pulses once, 1 cycle wide, on the 2nd cycle after nrst rises; wave_out=0 until note_valid.
- note=9 (A3): wave_out high 22727 cycles then low 22727; after 100000 PLAY cycles, 10 cycles of 0; then a new note_req.
- note=21 gives a half-period of 11363. note=63 (D#, octave 5) gives 1004. cur_note must equal the captured value.
- Extra note_valid strobes during PLAY/GAP: no effect on cur_note or timing.
- en dropped mid-PLAY: wave_out=0 and busy=0 next cycle, state IDLE. en and note_valid together with en=0: no capture.
- nrst asserted mid-PLAY: all outputs 0 immediately. With REST_EN, note=0: wave_out stays 0 for 100000 cycles while busy=1.

Source files
------------

// File: rtl/note_pkg.sv
// note_pkg: FSM states, the octave-0 half-period table and note splitting
// shared by note_player and its testbench-facing top.
package note_pkg;

  localparam int NOTE_W        = 6;
  localparam int BASE_W        = 16;
  localparam int NOTES_PER_OCT = 12;
  localparam int NUM_OCT       = 6;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    PLAY = 3'd3,
    GAP  = 3'd4
  } state_t;

  typedef struct packed {
    logic [2:0] octave;
    logic [3:0] semitone;
  } note_pos_t;

  // Octave-0 (C3..B3) half periods in 10 MHz clocks; G# = 24079 fills the chromatic row.
  localparam logic [BASE_W-1:0] BASE_HALF [NOTES_PER_OCT] = '{
    16'd38223, 16'd36077, 16'd34052, 16'd32141, 16'd30337, 16'd28635,
    16'd27027, 16'd25510, 16'd24079, 16'd22727, 16'd21452, 16'd20248
  };

  // Octave/semitone split by a compare chain so no divider is built.
  function automatic note_pos_t split_note(input logic [NOTE_W-1:0] n);
    note_pos_t        p;
    logic [NOTE_W-1:0] rem;
    if (n >= 6'd60) begin
      p.octave = 3'd5;
      rem      = n - 6'd60;
    end else if (n >= 6'd48) begin
      p.octave = 3'd4;
      rem      = n - 6'd48;
    end else if (n >= 6'd36) begin
      p.octave = 3'd3;
      rem      = n - 6'd36;
    end else if (n >= 6'd24) begin
      p.octave = 3'd2;
      rem      = n - 6'd24;
    end else if (n >= 6'd12) begin
      p.octave = 3'd1;
      rem      = n - 6'd12;
    end else begin
      p.octave = 3'd0;
      rem      = n;
    end
    p.semitone = rem[3:0];
    return p;
  endfunction

endpackage

// File: rtl/note_player_tone_gen.sv
// tone_gen: square-wave generator holding the half-period counter and toggle flop.
// A half period of 0 produces silence (used for rests).
module tone_gen
  import note_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             load,
  input  logic [DIV_W-1:0] half_period,
  input  logic             run,
  output logic             wave
);

  logic [DIV_W-1:0] cnt_reg;
  logic [DIV_W-1:0] hp_reg;
  logic             wave_reg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_reg  <= '0;
      hp_reg   <= '0;
      wave_reg <= 1'b0;
    end else if (load) begin
      // First cycle after load is already high so the note starts on a rising edge.
      hp_reg   <= half_period;
      cnt_reg  <= '0;
      wave_reg <= (half_period != '0);
    end else if (!run) begin
      cnt_reg  <= '0;
      wave_reg <= 1'b0;
    end else if (hp_reg == '0) begin
      cnt_reg  <= '0;
      wave_reg <= 1'b0;
    end else if (cnt_reg == hp_reg - DIV_W'(1)) begin
      cnt_reg  <= '0;
      wave_reg <= ~wave_reg;
    end else begin
      cnt_reg  <= cnt_reg + DIV_W'(1);
    end
  end

  assign wave = wave_reg;

endmodule

// File: rtl/note_player.sv
// note_player: requests a note, plays it as a square wave for NOTE_CYCLES,
// then stays silent for GAP_CYCLES. Optional macro REST_EN makes note 0 a rest.
module note_player
  import note_pkg::*;
#(
  parameter int NOTE_CYCLES = 2500000,
  parameter int GAP_CYCLES  = 250000,
  parameter int DIV_W       = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              note_valid,
  input  logic [NOTE_W-1:0] note,
  output logic              note_req,
  output logic              wave_out,
  output logic              busy,
  output logic [NOTE_W-1:0] cur_note
);

  localparam int CNT_MAX = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [NOTE_W-1:0] cur_note_reg, cur_note_next;
  logic              capture;
  logic              tone_run;

  note_pos_t         pos;
  logic [BASE_W-1:0] shifted [NUM_OCT];
  logic [BASE_W-1:0] oct_half;
  logic [DIV_W-1:0]  half_period;

  assign pos = split_note(note);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OCT; gi++) begin : g_oct
      assign shifted[gi] = BASE_HALF[pos.semitone] >> gi;
    end
  endgenerate

  always_comb begin
    oct_half = shifted[0];
    case (pos.octave)
      3'd1:    oct_half = shifted[1];
      3'd2:    oct_half = shifted[2];
      3'd3:    oct_half = shifted[3];
      3'd4:    oct_half = shifted[4];
      3'd5:    oct_half = shifted[5];
      default: oct_half = shifted[0];
    endcase
    if (oct_half == '0) begin
      oct_half = BASE_W'(1);
    end
    half_period = DIV_W'(oct_half);
`ifdef REST_EN
    if (note == '0) begin
      half_period = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      cur_note_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      cur_note_reg <= cur_note_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    cur_note_next = cur_note_reg;
    capture       = 1'b0;
    // Dropping en aborts whatever is in flight, including a coincident note_valid.
    if (!en && state_reg != IDLE) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (en) begin
            state_next = REQ;
          end
        end
        REQ: begin
          state_next = WAIT;
        end
        WAIT: begin
          if (note_valid) begin
            capture       = 1'b1;
            cur_note_next = note;
            cnt_next      = '0;
            state_next    = PLAY;
          end
        end
        PLAY: begin
          if (cnt_reg == NOTE_LAST) begin
            cnt_next   = '0;
            state_next = GAP;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_reg == GAP_LAST) begin
            cnt_next   = '0;
            state_next = REQ;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Tone only runs while the next cycle is still PLAY, so wave drops the cycle PLAY ends.
  assign tone_run = (state_next == PLAY);

  tone_gen #(
    .DIV_W(DIV_W)
  ) u_tone (
    .clk        (clk),
    .nrst       (nrst),
    .load       (capture),
    .half_period(half_period),
    .run        (tone_run),
    .wave       (wave_out)
  );

  assign note_req = (state_reg == REQ);
  assign busy     = (state_reg == PLAY) || (state_reg == GAP);
  assign cur_note = cur_note_reg;

endmodule
